// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and baud divider helper for the UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // Clocks per bit, rounded to nearest so the bit period error stays under half a clock.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a pop never frees space for a same-cycle push
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter with configurable framing
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          enable,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          Tx,
    output logic                          busy,
    output logic                          done
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW  = $clog2(DIV);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_START = ST_START;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_PAR   = ST_PAR;
    localparam logic [2:0] S_STOP  = ST_STOP;

    logic [2:0]           state;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 par_bit;
    logic                 tx_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 start_frame;
    logic                 word_par;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (enable),
        .din   (din),
        .pop   (start_frame),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign bit_end     = (baud_cnt == CW'(DIV - 1));
    assign done        = (state == S_STOP) && bit_end && (bit_cnt == 4'(STOP_BITS - 1));
    // A frame starts from IDLE or straight out of the final stop clock, so queued words leave no gap.
    assign start_frame = !fifo_empty && ((state == S_IDLE) || done);
    assign word_par    = ^fifo_dout;
    assign busy        = (state != S_IDLE);
    assign ready       = !fifo_full;
    assign Tx          = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            overflow <= enable && fifo_full;
            if (start_frame) begin
                state    <= S_START;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= fifo_dout;
                par_bit  <= (PARITY == int'(ODD)) ? ~word_par : word_par;
                tx_q     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        baud_cnt <= '0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            state    <= S_DATA;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            tx_q     <= shreg[0];
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (bit_cnt == 4'(DATA_BITS - 1)) begin
                                bit_cnt <= '0;
                                if (PARITY != int'(NONE)) begin
                                    state <= S_PAR;
                                    tx_q  <= par_bit;
                                end else begin
                                    state <= S_STOP;
                                    tx_q  <= 1'b1;
                                end
                            end else begin
                                shreg   <= shreg >> 1;
                                tx_q    <= shreg[1];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    S_PAR: begin
                        if (bit_end) begin
                            state    <= S_STOP;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            tx_q     <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (done) begin
                                state <= S_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        baud_cnt <= '0;
                        tx_q     <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
